// File: rtl/asi_burst_agen.sv
// asi_burst_agen: AXI burst beat generator (cmd_* in -> beat_* descriptors out, cmd_err on illegal, busy during burst)
module asi_burst_agen #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 40,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int AXI_BURSTW = 2,
  parameter int CHK_4K = 1,
  localparam int BYTES = AXI_DW / 8,
  localparam int LANEW = $clog2(BYTES)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [AXI_LW-1:0]     cmd_len,
  input  logic [AXI_SW-1:0]     cmd_size,
  input  logic [AXI_BURSTW-1:0] cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [AXI_AW-1:0]     beat_addr,
  output logic [LANEW-1:0]      beat_lane_lo,
  output logic [LANEW-1:0]      beat_lane_hi,
  output logic [AXI_LW-1:0]     beat_idx,
  output logic                  beat_last,
  output logic                  cmd_err,
  output logic                  busy
);
  localparam logic [AXI_BURSTW-1:0] FIXED = AXI_BURSTW'(0);
  localparam logic [AXI_BURSTW-1:0] INCR = AXI_BURSTW'(1);
  localparam logic [AXI_BURSTW-1:0] WRAP = AXI_BURSTW'(2);
  localparam logic [AXI_BURSTW-1:0] RSVD = AXI_BURSTW'(3);
  typedef enum logic {IDLE, BURST} state_e;
  state_e state_q, state_d;
  logic [AXI_AW-1:0] addr_q, addr_d, wmask_q, wmask_d;
  logic [AXI_LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [AXI_SW-1:0] size_q, size_d;
  logic [AXI_BURSTW-1:0] burst_q, burst_d;
  logic err_q, err_d;
  logic [AXI_AW-1:0] szm_c, wm_c, end_c, lenx_c, szm_q, inc_q, nxt_q;
  logic wlen_ok, illegal, acc, fire;
  assign lenx_c = AXI_AW'(cmd_len);
  assign szm_c = (AXI_AW'(1) << cmd_size) - AXI_AW'(1);
  assign wm_c = ((lenx_c + AXI_AW'(1)) << cmd_size) - AXI_AW'(1);
  // last byte-beat start of an INCR burst, used for the 4KB page check
  assign end_c = (cmd_addr & ~szm_c) + (lenx_c << cmd_size);
  assign wlen_ok = cmd_len == AXI_LW'(1) || cmd_len == AXI_LW'(3) || cmd_len == AXI_LW'(7) || cmd_len == AXI_LW'(15);
  assign illegal = cmd_burst == RSVD
                || (cmd_burst == WRAP && (!wlen_ok || (cmd_addr & szm_c) != '0))
                || cmd_size > AXI_SW'(LANEW)
                || (cmd_burst == FIXED && cmd_len > AXI_LW'(15))
                || (CHK_4K != 0 && cmd_burst == INCR && cmd_addr[AXI_AW-1:12] != end_c[AXI_AW-1:12]);
  assign szm_q = (AXI_AW'(1) << size_q) - AXI_AW'(1);
  assign inc_q = (addr_q & ~szm_q) + szm_q + AXI_AW'(1);
  // wrap keeps the upper bits of the window and lets only the in-window offset roll over
  assign nxt_q = burst_q == FIXED ? addr_q : burst_q == WRAP ? ((addr_q & ~wmask_q) | (inc_q & wmask_q)) : inc_q;
  assign beat_valid = state_q == BURST;
  assign busy = beat_valid;
  assign beat_last = beat_valid && idx_q == len_q;
  assign fire = beat_valid & beat_ready;
  assign cmd_ready = state_q == IDLE || (fire && beat_last);
  assign acc = cmd_valid & cmd_ready;
  assign beat_addr = addr_q;
  assign beat_idx = idx_q;
  assign beat_lane_lo = addr_q[LANEW-1:0];
  assign beat_lane_hi = addr_q[LANEW-1:0] | szm_q[LANEW-1:0];
  assign cmd_err = err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wmask_d = wmask_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    idx_d = idx_q;
    err_d = 1'b0;
    if (acc) begin
      err_d = illegal;
      state_d = illegal ? IDLE : BURST;
      if (!illegal) begin
        addr_d = cmd_addr;
        wmask_d = wm_c;
        len_d = cmd_len;
        size_d = cmd_size;
        burst_d = cmd_burst;
        idx_d = '0;
      end
    end else if (fire) begin
      state_d = beat_last ? IDLE : BURST;
      addr_d = beat_last ? addr_q : nxt_q;
      idx_d = beat_last ? idx_q : idx_q + AXI_LW'(1);
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      wmask_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wmask_q <= wmask_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_asi_burst_agen.sv
// tb_asi_burst_agen: directed self-checking bench for asi_burst_agen
module tb_asi_burst_agen;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic cmd_valid = 1'b0, beat_ready = 1'b1;
  logic cmd_ready, beat_valid, beat_last, cmd_err, busy;
  logic [39:0] cmd_addr = '0, beat_addr;
  logic [7:0] cmd_len = '0, beat_idx;
  logic [2:0] cmd_size = '0;
  logic [1:0] cmd_burst = '0;
  logic [3:0] beat_lane_lo, beat_lane_hi;
  int checks = 0, fails = 0;
  always #5 ACLK = ~ACLK;
  asi_burst_agen dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_lane_lo(beat_lane_lo), .beat_lane_hi(beat_lane_hi), .beat_idx(beat_idx),
    .beat_last(beat_last), .cmd_err(cmd_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic set_cmd(input logic [39:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    cmd_size = s;
    cmd_burst = b;
  endtask
  task automatic send(input logic [39:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    set_cmd(a, l, s, b);
    #1;
    chk("send_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_addr = 40'hFFFF_FFFF;
  endtask
  task automatic beat(input string tag, input logic [39:0] a, input int lo, input int hi, input int idx, input logic last);
    chk({tag, "_valid"}, beat_valid, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_addr"}, beat_addr, a);
    chk({tag, "_lo"}, beat_lane_lo, lo);
    chk({tag, "_hi"}, beat_lane_hi, hi);
    chk({tag, "_idx"}, beat_idx, idx);
    chk({tag, "_last"}, beat_last, last);
    tick();
  endtask
  task automatic idle(input string tag);
    chk({tag, "_idle_valid"}, beat_valid, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
  endtask
  task automatic bad(input string tag, input logic [39:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    send(a, l, s, b);
    chk({tag, "_err"}, cmd_err, 1'b1);
    idle(tag);
    tick();
    chk({tag, "_err_clr"}, cmd_err, 1'b0);
    idle({tag, "_after"});
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_addr", beat_addr, 0);
    chk("rst_last", beat_last, 1'b0);
    ARESET = 1'b0;
    tick();
    send(40'h1003, 8'd2, 3'd2, 2'd1);
    beat("incr0", 40'h1003, 3, 3, 0, 1'b0);
    beat("incr1", 40'h1004, 4, 7, 1, 1'b0);
    beat("incr2", 40'h1008, 8, 11, 2, 1'b1);
    idle("incr");
    send(40'h30, 8'd3, 3'd4, 2'd2);
    beat("wrap0", 40'h30, 0, 15, 0, 1'b0);
    beat("wrap1", 40'h00, 0, 15, 1, 1'b0);
    beat("wrap2", 40'h10, 0, 15, 2, 1'b0);
    beat("wrap3", 40'h20, 0, 15, 3, 1'b1);
    idle("wrap");
    send(40'h20, 8'd3, 3'd4, 2'd0);
    beat("fix0", 40'h20, 0, 15, 0, 1'b0);
    beat_ready = 1'b0;
    repeat (3) begin
      chk("stall_valid", beat_valid, 1'b1);
      chk("stall_addr", beat_addr, 40'h20);
      chk("stall_idx", beat_idx, 1);
      chk("stall_ready", cmd_ready, 1'b0);
      tick();
    end
    beat_ready = 1'b1;
    beat("fix1", 40'h20, 0, 15, 1, 1'b0);
    beat("fix2", 40'h20, 0, 15, 2, 1'b0);
    beat("fix3", 40'h20, 0, 15, 3, 1'b1);
    idle("fix");
    bad("x4k", 40'hFF0, 8'd1, 3'd4, 2'd1);
    bad("rsvd", 40'h0, 8'd0, 3'd2, 2'd3);
    bad("wlen", 40'h0, 8'd2, 3'd2, 2'd2);
    bad("size5", 40'h0, 8'd0, 3'd5, 2'd1);
    send(40'h200, 8'd1, 3'd4, 2'd1);
    beat("b2b0", 40'h200, 0, 15, 0, 1'b0);
    set_cmd(40'h100, 8'd0, 3'd4, 2'd1);
    #1;
    chk("b2b_ready", cmd_ready, 1'b1);
    beat("b2b1", 40'h210, 0, 15, 1, 1'b1);
    cmd_valid = 1'b0;
    beat("b2b2", 40'h100, 0, 15, 0, 1'b1);
    idle("b2b");
    send(40'h0, 8'd7, 3'd4, 2'd1);
    beat("rb0", 40'h00, 0, 15, 0, 1'b0);
    beat("rb1", 40'h10, 0, 15, 1, 1'b0);
    chk("rb2_addr", beat_addr, 40'h20);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    idle("rst_mid");
    chk("rst_mid_idx", beat_idx, 0);
    send(40'h40, 8'd1, 3'd2, 2'd1);
    beat("post0", 40'h40, 0, 3, 0, 1'b0);
    beat("post1", 40'h44, 4, 7, 1, 1'b1);
    idle("post");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/asi_burst_agen.md
Name: asi_burst_agen

Overview:
- Parametrised AXI burst address/beat generator for the ASI slave datapath.
- Accepts one decoded AW/AR command (addr, len, size, burst) and emits one beat descriptor per data transfer: beat address, active byte-lane window, beat index and last flag.
- Supports FIXED, INCR and WRAP bursts, narrow and unaligned transfers, and back-to-back commands.
- Flags illegal commands (reserved burst, bad wrap length or alignment, oversize, 4KB crossing) instead of generating beats for them.

Parameters:
- AXI_DW, 128, data bus width in bits (power of 2, ≥ 32); BYTES = AXI_DW/8, LANEW = log2(BYTES).
- AXI_AW, 40, address width.
- AXI_LW, 8, burst length field width (beats = len+1).
- AXI_SW, 3, size field width (bytes per beat = 2**size).
- AXI_BURSTW, 2, burst type width; FIXED=0, INCR=1, WRAP=2, RESERVED=3.
- CHK_4K, 1, 1 = INCR bursts crossing a 4KB boundary are errors; 0 = no check.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AXI_AW  start address.
- cmd_len  in  AXI_LW  beats minus one.
- cmd_size  in  AXI_SW  log2 bytes per beat.
- cmd_burst  in  AXI_BURSTW  burst type.
- beat_valid  out  1  beat descriptor valid.
- beat_ready  in  1  consumer takes beat.
- beat_addr  out  AXI_AW  address of current beat.
- beat_lane_lo  out  LANEW  lowest active byte lane.
- beat_lane_hi  out  LANEW  highest active byte lane.
- beat_idx  out  AXI_LW  beat number, 0-based.
- beat_last  out  1  final beat of burst.
- cmd_err  out  1  one-cycle pulse: accepted command was illegal.
- busy  out  1  burst in progress.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE.
- Reset mid-burst drops the burst and emits no further beats.
- States:
  - IDLE: cmd_ready = 1, beat_valid = 0.
  - BURST: beat_valid = 1.
  - No other states.
- Command accept:
  - A legal command accepted in IDLE → BURST on the next cycle, with beat 0 presented (1-cycle latency).
  - An illegal command is consumed: cmd_err = 1 for exactly the next cycle, state stays IDLE, no beats are generated.
- Handshake:
  - Descriptor outputs hold stable while beat_valid & !beat_ready.
  - The beat advances only on beat_valid & beat_ready.
- Burst end and back-to-back:
  - On the handshake of the beat with beat_last = 1, cmd_ready = 1 combinationally.
  - If a command is accepted in that same cycle, the next command's beat 0 appears the following cycle (no bubble).
  - Otherwise return to IDLE.
- busy = (state == BURST).
- Address arithmetic, with SZ = 2**size and aligned(a) = a & ~(SZ-1):
  - FIXED: every beat uses cmd_addr.
  - INCR: beat 0 = cmd_addr; beat n = aligned(cmd_addr) + n*SZ. Arithmetic is modulo 2**AXI_AW.
  - WRAP: W = (len+1)*SZ, base = addr & ~(W-1). next = cur + SZ; if next == base + W, then next = base.
- Byte lanes:
  - lane_lo = beat_addr[LANEW-1:0].
  - lane_hi = (aligned(beat_addr) + SZ - 1)[LANEW-1:0].
  - FIXED bursts repeat the lanes of beat 0.
- beat_idx counts 0..len. beat_last = (beat_idx == len).
- Illegal command (any of the following):
  - burst == RESERVED.
  - WRAP with len not in {1, 3, 7, 15}.
  - WRAP with cmd_addr not SZ-aligned.
  - SZ > BYTES.
  - FIXED with len > 15.
  - CHK_4K = 1 and INCR with cmd_addr[AXI_AW-1:12] != (aligned(cmd_addr) + len*SZ)[AXI_AW-1:12].
- Legality is evaluated combinationally from the cmd_* inputs at accept time; it is not pipelined.
- Command fields are registered at accept. Later changes on cmd_* do not affect the running burst.

Test Plan:
- INCR, addr 0x1003, size 2, len 2 → beats 0x1003 (lanes 3..3), 0x1004 (4..7), 0x1008 (8..11); beat_last on idx 2.
- WRAP, addr 0x30, size 4, len 3 → beats 0x30, 0x00, 0x10, 0x20; all lanes 0..15; beat_last on the 0x20 beat.
- FIXED, addr 0x20, size 4, len 3, with beat_ready low for 3 cycles on beat 1 → four beats at 0x20; outputs stable during the stall; idx 0..3.
- Illegal commands → cmd_err one-cycle pulse, no beat_valid, cmd_ready stays 1:
  - INCR addr 0xFF0, size 4, len 1 (4KB cross).
  - burst = 3.
  - WRAP len 2.
  - size 5.
- Back-to-back: second command (INCR 0x100, size 4, len 0) held valid during the last beat of the first → its beat appears the next cycle, no idle cycle.
- ARESET asserted during beat 2 of an INCR len 7 burst → next cycle beat_valid = 0, busy = 0, cmd_ready = 1; a new command then runs from idx 0.
